// File: rtl/nes_joypad_pkg.sv
// Shared definitions for the NES joypad port: button indices, PS/2 scancodes
// and the open-bus value the CPU sees on the unused data bits.
package nes_joypad_pkg;

  // Button bit positions; this is also the order the serial port shifts them out.
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

  // PS/2 set-2 make codes (E0 prefix already stripped by the keyboard block).
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Upper bits float to the last opcode byte on a real NES; games expect 0x40.
  localparam logic [7:0] OPEN_BUS = 8'h40;

  // Returns {hit, buttonIndex}; hit=0 for codes that map to no button.
  function automatic logic [3:0] keyToButton(input logic [7:0] code);
    logic [3:0] result;
    result = 4'b0000;
    case (code)
      SC_K:     result = {1'b1, BTN_A};
      SC_J:     result = {1'b1, BTN_B};
      SC_SPACE: result = {1'b1, BTN_SELECT};
      SC_ENTER: result = {1'b1, BTN_START};
      SC_W:     result = {1'b1, BTN_UP};
      SC_S:     result = {1'b1, BTN_DOWN};
      SC_A:     result = {1'b1, BTN_LEFT};
      SC_D:     result = {1'b1, BTN_RIGHT};
      default:  result = 4'b0000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/nes_joypad_ps2_button_tracker.sv
// Keeps a held/released bit per NES button from the keyboard's last scancode
// and presents the live button vector, optionally suppressing opposing directions.
module ps2_button_tracker
  import nes_joypad_pkg::*;
#(
  parameter bit BLOCK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode_i,
  input  logic       keypress_i,
  output logic [7:0] keystates_o
);

  logic [7:0] btn_q;
  logic [7:0] btn_d;
  logic [3:0] keyHit;

  // Only the button named by the current scancode follows keypress; the rest hold.
  always_comb begin
    btn_d  = btn_q;
    keyHit = keyToButton(keycode_i);
    if (keyHit[3]) begin
      btn_d[keyHit[2:0]] = keypress_i;
    end
  end

  // Button state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 8'h00;
    end else begin
      btn_q <= btn_d;
    end
  end

  // A d-pad cannot press both opposing directions; report neither when both are held.
  always_comb begin
    keystates_o = btn_q;
    if (BLOCK_OPPOSING) begin
      if (btn_q[BTN_UP] && btn_q[BTN_DOWN]) begin
        keystates_o[BTN_UP]   = 1'b0;
        keystates_o[BTN_DOWN] = 1'b0;
      end
      if (btn_q[BTN_LEFT] && btn_q[BTN_RIGHT]) begin
        keystates_o[BTN_LEFT]  = 1'b0;
        keystates_o[BTN_RIGHT] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nes_joypad.sv
// NES controller port at $4016/$4017: strobe latch, serial shift register
// advanced on the trailing edge of each $4016 read, and the CPU read mux.
module nes_joypad
  import nes_joypad_pkg::*;
#(
  parameter bit BLOCK_OPPOSING = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  input  logic       keypress,
  input  logic       cs,
  input  logic       addr0,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [7:0] keystates
);

  logic       strobe_q;
  logic       strobe_d;
  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic       rdHist_q;
  logic       rdHist_d;
  logic       rdAccess;
  logic       wrStrobe;
  logic       readEnd;
  logic       unusedData;

  ps2_button_tracker #(
    .BLOCK_OPPOSING(BLOCK_OPPOSING)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .keycode_i  (keycode),
    .keypress_i (keypress),
    .keystates_o(keystates)
  );

  assign rdAccess   = cs & ~we & ~addr0;
  assign wrStrobe   = cs & we & ~addr0;
  assign readEnd    = rdHist_q & ~rdAccess;
  assign unusedData = ^data_in[7:1];

  // Strobe follows bit0 of $4016 writes; the shifter reloads while strobe is high
  // (reload beats a coincident read-end), otherwise it advances once when a read ends.
  always_comb begin
    strobe_d = strobe_q;
    sr_d     = sr_q;
    rdHist_d = rdAccess;
    if (wrStrobe) begin
      strobe_d = data_in[0];
    end
    if (strobe_q) begin
      sr_d = keystates;
    end else if (readEnd) begin
      sr_d = {1'b1, sr_q[7:1]};
    end
  end

  // Port state registers; reset also clears the read history so a read cut by
  // reset cannot produce a shift afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_q <= 1'b0;
      sr_q     <= 8'h00;
      rdHist_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      sr_q     <= sr_d;
      rdHist_q <= rdHist_d;
    end
  end

  // Only a $4016 read drives the serial bit; everything else reads as open bus.
  always_comb begin
    data_out = OPEN_BUS;
    if (rdAccess) begin
      data_out = {OPEN_BUS[7:1], sr_q[0]};
    end
  end

endmodule

// File: tb/tb_nes_joypad.sv
// Self-checking bench for nes_joypad: table of per-cycle vectors pushed into a
// scoreboard queue and compared against the DUT mid-cycle.
module tb_nes_joypad;

  logic       clk;
  logic       reset;
  logic [7:0] keycode;
  logic       keypress;
  logic       cs;
  logic       addr0;
  logic       we;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] keystates;

  int compared;
  int mismatched;
  int vecIdx;

  typedef struct {
    logic       rst;
    logic [7:0] kc;
    logic       kp;
    logic       cs;
    logic       a0;
    logic       we;
    logic [7:0] din;
    logic [7:0] expD;
    logic [7:0] expK;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  nes_joypad #(
    .BLOCK_OPPOSING(1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .keycode  (keycode),
    .keypress (keypress),
    .cs       (cs),
    .addr0    (addr0),
    .we       (we),
    .data_in  (data_in),
    .data_out (data_out),
    .keystates(keystates)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so a stuck run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic rst, input logic [7:0] kc, input logic kp,
                        input logic c, input logic a0, input logic w,
                        input logic [7:0] din, input logic [7:0] expD,
                        input logic [7:0] expK);
    vec_t v;
    v.rst = rst; v.kc = kc; v.kp = kp; v.cs = c; v.a0 = a0; v.we = w;
    v.din = din; v.expD = expD; v.expK = expK;
    vecs.push_back(v);
  endtask

  task automatic vKey(input logic [7:0] kc, input logic kp, input logic [7:0] expK);
    addVec(1'b0, kc, kp, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, expK);
  endtask

  task automatic vIdle(input logic [7:0] expK);
    addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, expK);
  endtask

  task automatic vRd(input logic [7:0] expD, input logic [7:0] expK);
    addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, expD, expK);
  endtask

  task automatic vRd17(input logic [7:0] expK);
    addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40, expK);
  endtask

  task automatic vWr(input logic [7:0] din, input logic [7:0] expK);
    addVec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, din, 8'h40, expK);
  endtask

  // Pops the oldest expectation and compares both outputs.
  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      mismatched++;
      compared++;
      $display("[TB] FAIL scoreboard_empty vec %0d: got empty queue, required entry", vecIdx);
      return;
    end
    e = sb.pop_front();
    compared++;
    if (data_out !== e.expD) begin
      mismatched++;
      $display("[TB] FAIL data_out vec %0d: got %02h, required %02h", vecIdx, data_out, e.expD);
    end
    compared++;
    if (keystates !== e.expK) begin
      mismatched++;
      $display("[TB] FAIL keystates vec %0d: got %02h, required %02h", vecIdx, keystates, e.expK);
    end
  endtask

  // Drives one cycle of inputs just after the clock edge and checks at the falling edge.
  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    keycode  = v.kc;
    keypress = v.kp;
    cs       = v.cs;
    addr0    = v.a0;
    we       = v.we;
    data_in  = v.din;
    sb.push_back(v);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    vecIdx++;
  endtask

  initial begin
    logic [7:0] expSeq[10];
    logic [7:0] expSeq2[8];
    compared   = 0;
    mismatched = 0;
    vecIdx     = 0;

    expSeq  = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
    expSeq2 = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};

    // Reset state, then K+Enter latched and read out serially.
    vRd(8'h40, 8'h00);
    vKey(8'h42, 1'b1, 8'h00);
    vKey(8'h5A, 1'b1, 8'h01);
    vIdle(8'h09);
    vWr(8'h01, 8'h09);
    vWr(8'h00, 8'h09);
    for (int i = 0; i < 10; i++) begin
      vRd(expSeq[i], 8'h09);
      vIdle(8'h09);
    end

    // Opposing-direction masking, vertical then horizontal.
    vKey(8'h42, 1'b0, 8'h09);
    vKey(8'h5A, 1'b0, 8'h08);
    vKey(8'h1D, 1'b1, 8'h00);
    vKey(8'h1B, 1'b1, 8'h10);
    vKey(8'h1B, 1'b0, 8'h00);
    vKey(8'h1C, 1'b1, 8'h10);
    vKey(8'h23, 1'b1, 8'h50);
    vKey(8'h1C, 1'b0, 8'h10);
    vKey(8'h23, 1'b0, 8'h90);
    vKey(8'h1D, 1'b0, 8'h10);
    vIdle(8'h00);

    // Latch A only, press D while strobe is low, then re-strobe and read all 8.
    vKey(8'h42, 1'b1, 8'h00);
    vIdle(8'h01);
    vWr(8'h01, 8'h01);
    vWr(8'h00, 8'h01);
    addVec(1'b0, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 8'h01);
    vIdle(8'h81);
    vRd(8'h40, 8'h81);
    vIdle(8'h81);
    vWr(8'h01, 8'h81);
    vWr(8'h00, 8'h81);
    for (int i = 0; i < 8; i++) begin
      vRd(expSeq2[i], 8'h81);
      vIdle(8'h81);
    end

    // Multi-cycle read shifts once; $4017 read leaves the shifter alone.
    vKey(8'h3B, 1'b1, 8'h81);
    vIdle(8'h83);
    vWr(8'h01, 8'h83);
    vWr(8'h00, 8'h83);
    vRd(8'h41, 8'h83);
    vRd(8'h41, 8'h83);
    vRd(8'h41, 8'h83);
    vIdle(8'h83);
    vRd17(8'h83);
    vIdle(8'h83);
    vRd(8'h41, 8'h83);
    vIdle(8'h83);
    vRd(8'h40, 8'h83);
    vIdle(8'h83);

    // Reads while strobe is high follow live A and leave no shift behind.
    vWr(8'h01, 8'h83);
    addVec(1'b0, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 8'h83);
    vRd(8'h41, 8'h82);
    vRd(8'h40, 8'h82);
    vIdle(8'h82);
    vWr(8'h00, 8'h82);
    vRd(8'h40, 8'h82);
    vIdle(8'h82);
    vRd(8'h41, 8'h82);
    vIdle(8'h82);

    reset    = 1'b1;
    keycode  = 8'h00;
    keypress = 1'b0;
    cs       = 1'b0;
    addr0    = 1'b0;
    we       = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Hand sequence: reset lands mid-read; the read's trailing edge must not shift.
    begin
      vec_t v;
      v.kc = 8'h00; v.kp = 1'b0; v.a0 = 1'b0; v.din = 8'h00;
      v.rst = 1'b0; v.cs = 1'b1; v.we = 1'b1; v.din = 8'h01; v.expD = 8'h40; v.expK = 8'h82;
      applyStimulus(v);
      v.din = 8'h00;
      applyStimulus(v);
      v.we = 1'b0; v.expD = 8'h40;
      applyStimulus(v);
      v.cs = 1'b0;
      applyStimulus(v);
      v.cs = 1'b1; v.expD = 8'h41;
      applyStimulus(v);
      v.rst = 1'b1;
      applyStimulus(v);
      v.rst = 1'b0; v.cs = 1'b0; v.expD = 8'h40; v.expK = 8'h00;
      applyStimulus(v);
      for (int i = 0; i < 9; i++) begin
        v.cs = 1'b1;
        v.expD = (i == 8) ? 8'h41 : 8'h40;
        applyStimulus(v);
        v.cs = 1'b0;
        v.expD = 8'h40;
        applyStimulus(v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nes_joypad.md
# nes_joypad

Standard NES controller port at CPU addresses $4016/$4017, fed by the PS/2 keyboard decoder. It sits between the `keyboard` block's `keyCode`/`press` outputs and the CPU bus in `cpu_toplevel`. It maps eight PS/2 keys to NES buttons and holds the live button vector. It implements the $4016 strobe/latch plus serial-read protocol that games poll each frame.

## Interface
Parameters:
- BLOCK_OPPOSING, 1: when 1, Up+Down held together reports neither; Left+Right likewise.

Ports:
- clk  in  1  system clock, same domain as `keyboard`. No synchronizer.
- reset  in  1  synchronous, active-high.
- keycode  in  8  last PS/2 set-2 make code (E0 prefix already stripped).
- keypress  in  1  1 = key `keycode` currently held, 0 = released.
- cs  in  1  joypad register select ($4016 or $4017 decoded).
- addr0  in  1  0 = $4016, 1 = $4017.
- we  in  1  1 = write access, 0 = read access.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data.
- keystates  out  8  live button vector, for the HEX display.

## Operation
- Button bit order, also the shift order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- Keymap:
  - A=K 0x42, B=J 0x3B
  - Select=Space 0x29, Start=Enter 0x5A
  - Up=W 0x1D, Down=S 0x1B, Left=A 0x1C, Right=D 0x23
- Unmapped codes are ignored.
- Button tracker:
  - Every cycle, if `keycode` maps to button i, then btn[i] <= keypress.
  - All other bits hold their value.
  - Because only the last code is visible, holding K then pressing W keeps A=1.
- keystates = btn after the opposing-direction mask. The mask is applied only when BLOCK_OPPOSING=1.
- Strobe register:
  - A write with cs & we & ~addr0 sets strobe <= data_in[0].
  - Writes with addr0=1 are ignored (APU frame counter is elsewhere).
- Shift register sr[7:0]:
  - While strobe=1, sr <= keystates every cycle.
  - While strobe=0, sr holds its value, except that it shifts right once per completed $4016 read: sr <= {1'b1, sr[7:1]}.
- A read access is defined as cs & ~we & ~addr0, and may last several cycles. The shift occurs in the cycle after the access ends (falling edge of the access), so multi-cycle reads return a stable bit.
- data_out is combinational:
  - $4016 read: {3'b010, 4'b0000, sr[0]} (0x40 open-bus high bits).
  - $4017 read: 0x40 (no second controller, bit0=0).
  - Not selected: 0x40.
- After 8 reads, every further read returns 0x41 until the next strobe.

## Timing
- Reset values: btn=0, keystates=0x00, strobe=0, sr=0x00, data_out=0x40, read-access history flop=0.
- keycode/keypress to keystates: 1 cycle.
- keystates to sr while strobe=1: 1 cycle.
- Strobe write takes effect the cycle after the write cycle.
- Latched value is the keystates of the last cycle in which strobe=1. The 1→0 write cycle itself still reloads.
- Simultaneous events:
  - Read-end shift in the same cycle as strobe=1: reload wins, no shift.
  - Reads while strobe=1 return live A (sr[0]) and cause no lasting shift.
  - Keys changing while strobe=0 do not affect sr.
- Reset mid-read: the access history clears, so no spurious shift after reset.

## Structure
- Package `nes_joypad_pkg` holds:
  - button index enum (BTN_A..BTN_RIGHT)
  - scancode localparams
  - OPEN_BUS = 8'h40
- Sub-module `ps2_button_tracker` holds the keymap decode, btn registers and opposing mask, and outputs keystates.
- The top level (`nes_joypad`) holds the strobe, shift register, access-edge detect and data_out mux.
- The top-level FPGA_NES block instantiates `nes_joypad` and drives keystates to HEX7/HEX6.

## Test plan
- Reset, then $4016 read: data_out=0x40, keystates=0x00.
- keycode=0x42 press=1, keycode=0x5A press=1 → keystates=0x09. Then write 1, write 0 to $4016 and do 8 single-cycle reads → bit0 sequence 1,0,0,1,0,0,0,0. 9th and 10th reads → 0x41.
- BLOCK_OPPOSING=1, W and S both pressed → keystates[5:4]=00. Release S → keystates=0x10.
- After latching 0x01, press D while strobe=0 → reads still return 1,0,... and keystates=0x81. Re-strobe → 8th read bit=1.
- 3-cycle $4016 read → data_out bit0 stable for all 3 cycles, exactly one shift afterwards. $4017 read → 0x40 and sr unchanged.
- Assert reset in the middle of a read sequence → sr=0x00 and strobe=0 next cycle, no shift on the deasserting edge of that read.
